// File: rtl/svm_seq.sv
// svm_seq: time-multiplexed two-layer fixed-point classifier with one-vs-one
// majority voting. One shared signed MAC evaluates every hidden neuron and
// every pair score in turn. A vote pass and an argmax step follow.
// Valid/ready handshakes are used on both the input side and the result side.
module svm_seq #(
    parameter int W       = 16,
    parameter int DIMS    = 21,
    parameter int INTER   = 6,
    parameter int CLASSES = 3,
    parameter int FRAC    = 8,
    parameter int RELU    = 1,
    localparam int NPAIR  = CLASSES * (CLASSES - 1) / 2,
    localparam int CW     = $clog2(CLASSES)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [DIMS*W-1:0]           din_i,
    input  logic [DIMS*INTER*W-1:0]     w1_i,
    input  logic [INTER*W-1:0]          b1_i,
    input  logic [INTER*NPAIR*W-1:0]    w2_i,
    input  logic [NPAIR*W-1:0]          b2_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [CW-1:0]               class_o,
    output logic [CLASSES*CW-1:0]       votes_o
);

    localparam int MAXN = (DIMS > INTER) ? DIMS : INTER;
    localparam int AW   = 2 * W + $clog2(MAXN + 1);
    localparam int CTW  = 16;

    localparam logic signed [AW-1:0] SMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_VOTE, S_DONE} state_t;

    // Bias aligned to the product scale so the accumulator can start from it.
    function automatic logic signed [AW-1:0] f_bias(input logic signed [W-1:0] b);
        logic signed [AW-1:0] t;
        t = {{(AW-W){b[W-1]}}, b};
        return t <<< FRAC;
    endfunction

    // Rescale by FRAC and clamp into the signed W-bit range.
    function automatic logic signed [W-1:0] f_sat(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] s;
        s = v >>> FRAC;
        if (s > SMAX)      return SMAX[W-1:0];
        else if (s < SMIN) return SMIN[W-1:0];
        else               return s[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] f_relu(input logic signed [W-1:0] v);
        if ((RELU != 0) && v[W-1]) return '0;
        return v;
    endfunction

    // Vote counters stick at their maximum instead of wrapping.
    function automatic logic [CW-1:0] f_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t                     r_state, w_next;
    logic [DIMS*W-1:0]          r_din;
    logic [DIMS*INTER*W-1:0]    r_w1;
    logic [INTER*W-1:0]         r_b1;
    logic [INTER*NPAIR*W-1:0]   r_w2;
    logic [NPAIR*W-1:0]         r_b2;
    logic [INTER*W-1:0]         r_hid;
    logic [NPAIR*W-1:0]         r_score;
    logic signed [AW-1:0]       r_acc;
    logic [CTW-1:0]             r_ia, r_ib, r_vi, r_vj;
    logic [CLASSES*CW-1:0]      r_vote, r_votes;
    logic [CW-1:0]              r_class;

    logic signed [W-1:0]        w_mul_a, w_mul_b, w_neu, w_vscore;
    logic signed [2*W-1:0]      w_prod;
    logic signed [AW-1:0]       w_sum;
    logic                       w_l1_last, w_l2_last;
    logic [CW-1:0]              w_win, w_best;
    int                         w_ia, w_ib, w_vidx;

    assign w_ia = int'(r_ia);
    assign w_ib = int'(r_ib);

    // Last MAC step of the last neuron in each layer.
    assign w_l1_last = (r_state == S_L1) && (r_ia == CTW'(DIMS-1)) && (r_ib == CTW'(INTER-1));
    assign w_l2_last = (r_state == S_L2) && (r_ia == CTW'(INTER-1)) && (r_ib == CTW'(NPAIR-1));

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid_i)            w_next = S_L1;
            S_L1:    if (w_l1_last)             w_next = S_L2;
            S_L2:    if (w_l2_last)             w_next = S_VOTE;
            S_VOTE:  if (r_ia == CTW'(NPAIR))   w_next = S_DONE;
            S_DONE:  if (out_ready_i)           w_next = S_IDLE;
            default:                            w_next = S_IDLE;
        endcase
    end

    // Handshake outputs depend on state only.
    always_comb begin
        in_ready_o  = (r_state == S_IDLE);
        out_valid_o = (r_state == S_DONE);
    end

    assign class_o = r_class;
    assign votes_o = r_votes;

    // MAC operand selection: feature x layer-1 weight, or hidden x layer-2 weight.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            S_L1: begin
                w_mul_a = r_din[w_ia*W +: W];
                w_mul_b = r_w1[(w_ia*INTER + w_ib)*W +: W];
            end
            S_L2: begin
                w_mul_a = r_hid[w_ia*W +: W];
                w_mul_b = r_w2[(w_ia*NPAIR + w_ib)*W +: W];
            end
            default: ;
        endcase
    end

    assign w_prod   = w_mul_a * w_mul_b;
    assign w_sum    = r_acc + {{(AW-2*W){w_prod[2*W-1]}}, w_prod};
    assign w_neu    = f_sat(w_sum);
    assign w_vscore = r_score[w_ia*W +: W];
    // Strictly positive score votes for the lower class of the pair.
    assign w_vidx   = (!w_vscore[W-1] && (w_vscore != '0)) ? int'(r_vi) : int'(r_vj);

    // Argmax over the vote counters; strict compare keeps the lowest index on ties.
    always_comb begin
        w_win  = '0;
        w_best = r_vote[CW-1:0];
        for (int c = 1; c < CLASSES; c++) begin
            if (r_vote[c*CW +: CW] > w_best) begin
                w_best = r_vote[c*CW +: CW];
                w_win  = CW'(c);
            end
        end
    end

    // Datapath: capture, layer-1 and layer-2 MAC sweeps, vote tally, result latch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc   <= '0;
            r_hid   <= '0;
            r_score <= '0;
            r_ia    <= '0;
            r_ib    <= '0;
            r_vi    <= '0;
            r_vj    <= '0;
            r_vote  <= '0;
            r_class <= '0;
            r_votes <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid_i) begin
                    r_din  <= din_i;
                    r_w1   <= w1_i;
                    r_b1   <= b1_i;
                    r_w2   <= w2_i;
                    r_b2   <= b2_i;
                    r_acc  <= f_bias(b1_i[W-1:0]);
                    r_ia   <= '0;
                    r_ib   <= '0;
                    r_vote <= '0;
                end
                S_L1: begin
                    if (r_ia == CTW'(DIMS-1)) begin
                        r_hid[w_ib*W +: W] <= f_relu(w_neu);
                        r_ia <= '0;
                        if (r_ib == CTW'(INTER-1)) begin
                            r_ib  <= '0;
                            r_acc <= f_bias(r_b2[W-1:0]);
                        end else begin
                            r_ib  <= r_ib + 1'b1;
                            r_acc <= f_bias(r_b1[(w_ib+1)*W +: W]);
                        end
                    end else begin
                        r_acc <= w_sum;
                        r_ia  <= r_ia + 1'b1;
                    end
                end
                S_L2: begin
                    if (r_ia == CTW'(INTER-1)) begin
                        r_score[w_ib*W +: W] <= w_neu;
                        r_ia <= '0;
                        if (r_ib == CTW'(NPAIR-1)) begin
                            r_ib <= '0;
                            r_vi <= '0;
                            r_vj <= CTW'(1);
                        end else begin
                            r_ib  <= r_ib + 1'b1;
                            r_acc <= f_bias(r_b2[(w_ib+1)*W +: W]);
                        end
                    end else begin
                        r_acc <= w_sum;
                        r_ia  <= r_ia + 1'b1;
                    end
                end
                S_VOTE: begin
                    if (r_ia < CTW'(NPAIR)) begin
                        r_vote[w_vidx*CW +: CW] <= f_inc(r_vote[w_vidx*CW +: CW]);
                        if (r_vj == CTW'(CLASSES-1)) begin
                            r_vi <= r_vi + 1'b1;
                            r_vj <= r_vi + CTW'(2);
                        end else begin
                            r_vj <= r_vj + 1'b1;
                        end
                        r_ia <= r_ia + 1'b1;
                    end else begin
                        r_class <= w_win;
                        r_votes <= r_vote;
                        r_ia    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
